rbm_stream_ctrl: RTL
====================

RBM_STREAM_CTRL -- requirements
Module: rbm_stream_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, stream word and result width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, base/length and CSR width.
REQ-003 SHALL have parameter RES_DEPTH, default 8, result FIFO depth (power of 2, >=4).
REQ-004 SHALL have port clk, in, 1, single clock for all logic.
REQ-005 SHALL have port reset_n, in, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port avs_s0_address, in, 3, CSR select.
REQ-007 SHALL have ports avs_s0_read and avs_s0_write, in, 1 each, CSR strobes.
REQ-008 SHALL have port avs_s0_writedata, in, ADDRESS_WIDTH, CSR write data.
REQ-009 SHALL have port avs_s0_readdata, out, ADDRESS_WIDTH, CSR read data.
REQ-010 SHALL have port avs_s0_readdatavalid, out, 1, read response strobe.
REQ-011 SHALL have port coe_control_fixed_location, out, 1, tied 0.
REQ-012 SHALL have ports coe_control_read_base and coe_control_read_length, out, ADDRESS_WIDTH each, reader setup.
REQ-013 SHALL have port coe_control_go, out, 1, reader start pulse.
REQ-014 SHALL have ports coe_control_done and coe_control_early_done, in, 1 each, reader status.
REQ-015 SHALL have port coe_user_buffer_data, in, DATAWIDTH, reader FIFO data.
REQ-016 SHALL have port coe_user_data_available, in, 1, reader FIFO non-empty.
REQ-017 SHALL have port coe_user_read_buffer, out, 1, reader FIFO pop.

Function
REQ-018 CSR map SHALL be: 0 base (RW), 1 length in bytes (RW), 2 control (W: bit0 start, bit1 clear, bit2 abort), 3 status (R), 4 result pop (R), 5 shift (RW, bits[4:0]).
REQ-019 Status SHALL be: bit0 busy, bit1 done (sticky), bit2 result FIFO empty, bit3 underflow (sticky), bit4 early_done seen (sticky), bits[15:8] result count.
REQ-020 Every read SHALL return readdatavalid exactly 1 cycle later with data; unmapped addresses read 0.
REQ-021 Writes to base, length, shift while busy SHALL be ignored.
REQ-022 FSM states SHALL be IDLE, GO, RUN, DRAIN, ABORT, DONE.
REQ-023 IDLE/DONE + start with length!=0: clear done and count, -> GO; length==0: -> DONE directly, no go pulse.
REQ-024 GO SHALL assert coe_control_go for exactly 1 cycle, then -> RUN; start while busy ignored.
REQ-025 RUN: coe_user_read_buffer = data_available AND (fifo_count + inflight) < RES_DEPTH, combinational.
REQ-026 Popped word SHALL pass 2 register stages (capture, then data << shift truncated to DATAWIDTH) and push to result FIFO; pop-to-push latency 2 cycles.
REQ-027 RUN -> DRAIN on coe_control_done; DRAIN -> DONE once data_available=0 and pipeline empty; done set on entry.
REQ-028 Result pop read: FIFO non-empty returns head and removes it; empty returns 0 and sets underflow.
REQ-029 Simultaneous push and pop SHALL keep count unchanged; count never exceeds RES_DEPTH.
REQ-030 Abort in GO/RUN/DRAIN SHALL flush pipeline and result FIFO, -> ABORT; ABORT pops and discards while data_available, -> IDLE on coe_control_done.
REQ-031 Clear SHALL zero done, underflow and early_done bits; ignored while busy.
REQ-032 busy SHALL be 1 in GO, RUN, DRAIN, ABORT.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, all CSRs, FIFO, pipeline and outputs to 0, including mid-transfer.
REQ-034 After reset, status SHALL read 0x4 (FIFO empty only).

Configuration
REQ-035 With RBM_SATURATE_EN defined, a shift losing set bits SHALL saturate result to all ones; undefined, result SHALL wrap (truncate).

Verification
REQ-036 base=0x1000, length=16, shift=1, start; words 3,5,7,9 -> go pulse 1 cycle, pops return 6,10,14,18, done=1.
REQ-037 Start with length=0 -> no go pulse, status done=1 next cycle.
REQ-038 RES_DEPTH=8, 12 words, no pops -> read_buffer stalls at 8 results, resumes after pops, all 12 in order.
REQ-039 Pop when empty -> readdata 0, underflow=1; clear -> underflow=0.
REQ-040 Data 0x80000001, shift=1 -> 0x00000002 without macro, 0xFFFFFFFF with RBM_SATURATE_EN.
REQ-041 Abort mid-RUN with 3 words pending, then done -> words discarded, FIFO empty, state IDLE, busy=0.

Source files
------------

// File: rtl/rbm_stream_ctrl.sv
// rtl/rbm_stream_ctrl.sv - CSR-driven stream reader controller with shift pipeline and result FIFO (optional macro: RBM_SATURATE_EN)
module rbm_stream_ctrl #(
    parameter int DATAWIDTH     = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int RES_DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               avs_s0_address,
    input  logic                     avs_s0_read,
    input  logic                     avs_s0_write,
    input  logic [ADDRESS_WIDTH-1:0] avs_s0_writedata,
    output logic [ADDRESS_WIDTH-1:0] avs_s0_readdata,
    output logic                     avs_s0_readdatavalid,
    output logic                     coe_control_fixed_location,
    output logic [ADDRESS_WIDTH-1:0] coe_control_read_base,
    output logic [ADDRESS_WIDTH-1:0] coe_control_read_length,
    output logic                     coe_control_go,
    input  logic                     coe_control_done,
    input  logic                     coe_control_early_done,
    input  logic [DATAWIDTH-1:0]     coe_user_buffer_data,
    input  logic                     coe_user_data_available,
    output logic                     coe_user_read_buffer
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(RES_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GO    = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] A_BASE   = 3'd0;
    localparam logic [2:0] A_LENGTH = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_RESULT = 3'd4;
    localparam logic [2:0] A_SHIFT  = 3'd5;

    logic [2:0]               state;
    logic [ADDRESS_WIDTH-1:0] base_reg;
    logic [ADDRESS_WIDTH-1:0] length_reg;
    logic [4:0]               shift_reg;
    logic                     done_flag;
    logic                     underflow_flag;
    logic                     early_flag;
    logic                     rdr_done;

    logic                     v1;
    logic                     v2;
    logic [DATAWIDTH-1:0]     d1;
    logic [DATAWIDTH-1:0]     d2;
    logic [DATAWIDTH-1:0]     shift_out;

    logic [DATAWIDTH-1:0]     mem [RES_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_count;
    logic [ADDRESS_WIDTH-1:0] head_ext;

    logic                     busy;
    logic                     stream_state;
    logic                     ctrl_wr;
    logic                     start_go;
    logic                     start_xfer;
    logic                     abort_go;
    logic                     clear_ok;
    logic                     res_rd;
    logic                     res_pop;
    logic                     push;
    logic                     flush;
    logic                     capture;
    logic [CW:0]              occ;
    logic [ADDRESS_WIDTH-1:0] status_val;
    logic [ADDRESS_WIDTH-1:0] rd_value;

    assign busy         = (state == S_GO) || (state == S_RUN) || (state == S_DRAIN) || (state == S_ABORT);
    assign stream_state = (state == S_RUN) || (state == S_DRAIN);
    assign ctrl_wr      = avs_s0_write && (avs_s0_address == A_CTRL);
    assign abort_go     = ctrl_wr && avs_s0_writedata[2] &&
                          ((state == S_GO) || (state == S_RUN) || (state == S_DRAIN));
    assign start_go     = ctrl_wr && avs_s0_writedata[0] && ((state == S_IDLE) || (state == S_DONE));
    assign start_xfer   = start_go && (length_reg != '0);
    assign clear_ok     = ctrl_wr && avs_s0_writedata[1] && !busy;
    assign res_rd       = avs_s0_read && (avs_s0_address == A_RESULT);
    assign res_pop      = res_rd && (fifo_count != '0);
    assign flush        = abort_go || start_xfer;
    assign push         = v2 && ((fifo_count < CW'(RES_DEPTH)) || res_pop);

    // Results already queued plus words still in the pipeline must fit in the FIFO.
    assign occ     = {1'b0, fifo_count} + {{CW{1'b0}}, v1} + {{CW{1'b0}}, v2};
    assign capture = stream_state && coe_user_data_available && (occ < DEPTH_L);

    assign coe_user_read_buffer       = capture || ((state == S_ABORT) && coe_user_data_available);
    assign coe_control_go             = (state == S_GO);
    assign coe_control_fixed_location = 1'b0;
    assign coe_control_read_base      = base_reg;
    assign coe_control_read_length    = length_reg;

    generate
        if (DATAWIDTH >= ADDRESS_WIDTH) begin : g_head_trunc
            assign head_ext = mem[rd_ptr][ADDRESS_WIDTH-1:0];
        end else begin : g_head_ext
            assign head_ext = {{(ADDRESS_WIDTH-DATAWIDTH){1'b0}}, mem[rd_ptr]};
        end
    endgenerate

    // Second pipeline stage arithmetic: left shift, wrapping or saturating on lost bits.
    always_comb begin
`ifdef RBM_SATURATE_EN
        logic [DATAWIDTH+31:0] wide;
        wide      = {{32{1'b0}}, d1} << shift_reg;
        shift_out = (|wide[DATAWIDTH+31:DATAWIDTH]) ? '1 : wide[DATAWIDTH-1:0];
`else
        shift_out = d1 << shift_reg;
`endif
    end

    // CSR read mux; status count is reported in bits 15:8.
    always_comb begin
        status_val       = '0;
        status_val[0]    = busy;
        status_val[1]    = done_flag;
        status_val[2]    = (fifo_count == '0);
        status_val[3]    = underflow_flag;
        status_val[4]    = early_flag;
        status_val[15:8] = 8'(fifo_count);
        rd_value         = '0;
        case (avs_s0_address)
            A_BASE:   rd_value = base_reg;
            A_LENGTH: rd_value = length_reg;
            A_STATUS: rd_value = status_val;
            A_RESULT: rd_value = (fifo_count != '0) ? head_ext : '0;
            A_SHIFT:  rd_value = {{(ADDRESS_WIDTH-5){1'b0}}, shift_reg};
            default:  rd_value = '0;
        endcase
    end

    // Read response is registered: data and valid appear one cycle after the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_s0_readdata      <= '0;
            avs_s0_readdatavalid <= 1'b0;
        end else begin
            avs_s0_readdatavalid <= avs_s0_read;
            if (avs_s0_read) begin
                avs_s0_readdata <= rd_value;
            end
        end
    end

    // Setup registers are frozen while a transfer owns them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg   <= '0;
            length_reg <= '0;
            shift_reg  <= '0;
        end else if (avs_s0_write && !busy) begin
            if (avs_s0_address == A_BASE)   base_reg   <= avs_s0_writedata;
            if (avs_s0_address == A_LENGTH) length_reg <= avs_s0_writedata;
            if (avs_s0_address == A_SHIFT)  shift_reg  <= avs_s0_writedata[4:0];
        end
    end

    // Sticky status flags; set events win over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_flag      <= 1'b0;
            underflow_flag <= 1'b0;
            early_flag     <= 1'b0;
            rdr_done       <= 1'b0;
        end else begin
            if (clear_ok) begin
                done_flag      <= 1'b0;
                underflow_flag <= 1'b0;
                early_flag     <= 1'b0;
            end
            if (start_xfer) begin
                done_flag <= 1'b0;
                rdr_done  <= 1'b0;
            end
            if ((start_go && !start_xfer) ||
                ((state == S_DRAIN) && !abort_go && !coe_user_data_available && !v1 && !v2)) begin
                done_flag <= 1'b1;
            end
            if (res_rd && (fifo_count == '0)) underflow_flag <= 1'b1;
            if (busy && coe_control_early_done) early_flag <= 1'b1;
            if (stream_state && coe_control_done) rdr_done <= 1'b1;
        end
    end

    // Transfer sequencing; abort from DRAIN exits at once since the reader already finished.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_go) state <= start_xfer ? S_GO : S_DONE;
                end
                S_GO: begin
                    state <= abort_go ? S_ABORT : S_RUN;
                end
                S_RUN: begin
                    if (abort_go)              state <= S_ABORT;
                    else if (coe_control_done) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (abort_go) state <= S_ABORT;
                    else if (!coe_user_data_available && !v1 && !v2) state <= S_DONE;
                end
                S_ABORT: begin
                    if (coe_control_done || rdr_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-stage pipeline: capture the popped word, then shift it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= capture;
            v2 <= v1;
            if (capture) d1 <= coe_user_buffer_data;
            if (v1)      d2 <= shift_out;
        end
    end

    // Result FIFO; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= d2;
                wr_ptr      <= wr_ptr + ONE_P;
            end
            if (res_pop) rd_ptr <= rd_ptr + ONE_P;
            if (push && !res_pop)      fifo_count <= fifo_count + ONE_C;
            else if (!push && res_pop) fifo_count <= fifo_count - ONE_C;
        end
    end

endmodule
